td4_exec: RTL and testbench

Execute/writeback stage of the TD4 core, directly downstream of `data_selector`. It takes the selected operand `y`, adds the 4-bit immediate, and writes the result into one of A (`r1`), B (`r2`), the output port, or the program counter, as decoded from the opcode. It also updates the carry flag. `r1` and `r2` feed back into `data_selector`, and `pc` addresses the instruction ROM, so the core retires one instruction per enabled clock.

---
 rtl/td4_exec.sv | 51 +++++
 tb/tb_td4_exec.sv | 156 +++++++++++++++
 2 files changed

// File: rtl/td4_exec.sv
// TD4 execute/writeback: adds the immediate to the selected operand and writes A, B, OUT or PC, plus the carry flag.
// Single-cycle: the next state is combinational from op/imm/sel_data/in_port; en=0 freezes every register.
module td4_exec (
    input  logic       clk,
    input  logic       rst,
    input  logic       en,
    input  logic [3:0] op,
    input  logic [3:0] imm,
    input  logic [3:0] sel_data,
    input  logic [3:0] in_port,
    output logic [3:0] r1,
    output logic [3:0] r2,
    output logic [3:0] out_port,
    output logic [3:0] pc,
    output logic       carry
);

    logic [3:0] src;
    logic [4:0] sum;
    logic       load_pc;

    always_comb begin
        src     = sel_data;
        if (!op[3] && op[1:0] == 2'b10) begin
            src = in_port;
        end
        sum     = {1'b0, src} + {1'b0, imm};
        // JNC tests the carry left by the previous instruction, not this one's carry-out.
        load_pc = (op[3:2] == 2'b11) && (op[0] || !carry);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r1       <= 4'h0;
            r2       <= 4'h0;
            out_port <= 4'h0;
            pc       <= 4'h0;
            carry    <= 1'b0;
        end else if (en) begin
            carry <= sum[4];
            case (op[3:2])
                2'b00:   r1       <= sum[3:0];
                2'b01:   r2       <= sum[3:0];
                2'b10:   out_port <= sum[3:0];
                default: ;
            endcase
            pc <= load_pc ? sum[3:0] : pc + 4'd1;
        end
    end

endmodule

// File: tb/tb_td4_exec.sv
// Bench for td4_exec: directed vector table from the test plan, then randomized cycles against a behavioural model.
module tb_td4_exec;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       en = 1'b0;
    logic [3:0] op = 4'h0;
    logic [3:0] imm = 4'h0;
    logic [3:0] sel_data = 4'h0;
    logic [3:0] in_port = 4'h0;
    logic [3:0] r1, r2, out_port, pc;
    logic       carry;

    td4_exec dut (
        .clk      (clk),
        .rst      (rst),
        .en       (en),
        .op       (op),
        .imm      (imm),
        .sel_data (sel_data),
        .in_port  (in_port),
        .r1       (r1),
        .r2       (r2),
        .out_port (out_port),
        .pc       (pc),
        .carry    (carry)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic       rst;
        logic       en;
        logic [3:0] op;
        logic [3:0] imm;
        logic [3:0] sel;
        logic [3:0] inp;
        logic [3:0] r1;
        logic [3:0] r2;
        logic [3:0] out;
        logic [3:0] pc;
        logic       c;
    } vec_t;

    vec_t tbl[$];
    int   n_vec = 0;
    int   n_bad = 0;

    // Behavioural model state, kept as plain integers.
    int m_r1, m_r2, m_out, m_pc, m_c;

    function automatic vec_t mk(input logic r, input logic e, input logic [3:0] o, input logic [3:0] i,
                                input logic [3:0] s, input logic [3:0] p, input logic [3:0] er1,
                                input logic [3:0] er2, input logic [3:0] eo, input logic [3:0] epc,
                                input logic ec);
        vec_t v;
        v = '{rst: r, en: e, op: o, imm: i, sel: s, inp: p, r1: er1, r2: er2, out: eo, pc: epc, c: ec};
        return v;
    endfunction

    task automatic apply(input logic r, input logic e, input logic [3:0] o, input logic [3:0] i,
                         input logic [3:0] s, input logic [3:0] p);
        @(negedge clk);
        rst      = r;
        en       = e;
        op       = o;
        imm      = i;
        sel_data = s;
        in_port  = p;
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [3:0] er1, input logic [3:0] er2,
                         input logic [3:0] eo, input logic [3:0] epc, input logic ec);
        n_vec++;
        if (r1 !== er1 || r2 !== er2 || out_port !== eo || pc !== epc || carry !== ec) begin
            n_bad++;
            $display("FAIL %s: got r1=%h r2=%h out=%h pc=%h c=%b, expected r1=%h r2=%h out=%h pc=%h c=%b",
                     name, r1, r2, out_port, pc, carry, er1, er2, eo, epc, ec);
        end
    endtask

    task automatic model_step(input logic r, input logic e, input int o, input int i, input int s,
                              input int p);
        int src, total;
        bit jump;
        if (r) begin
            m_r1 = 0; m_r2 = 0; m_out = 0; m_pc = 0; m_c = 0;
        end else if (e) begin
            src   = (o < 8 && (o % 4) == 2) ? p : s;
            total = src + i;
            case (o / 4)
                0: m_r1  = total % 16;
                1: m_r2  = total % 16;
                2: m_out = total % 16;
                default: ;
            endcase
            jump  = (o / 4 == 3) && ((o % 2) == 1 || m_c == 0);
            m_pc  = jump ? total % 16 : (m_pc + 1) % 16;
            m_c   = (total >= 16) ? 1 : 0;
        end
    endtask

    initial begin
        //          rst en  op     imm    sel    inp     r1     r2     out    pc    c
        tbl.push_back(mk(1, 0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 0));
        tbl.push_back(mk(1, 0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 0));
        tbl.push_back(mk(0, 1, 4'h3, 4'h5, 4'h0, 4'h0, 4'h5, 4'h0, 4'h0, 4'h1, 0));
        tbl.push_back(mk(0, 1, 4'h3, 4'hF, 4'h0, 4'h0, 4'hF, 4'h0, 4'h0, 4'h2, 0));
        tbl.push_back(mk(0, 1, 4'h0, 4'h1, 4'hF, 4'h0, 4'h0, 4'h0, 4'h0, 4'h3, 1));
        tbl.push_back(mk(0, 1, 4'hE, 4'hA, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h4, 0));
        tbl.push_back(mk(0, 1, 4'hE, 4'hA, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 4'hA, 0));
        tbl.push_back(mk(0, 1, 4'hF, 4'hF, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 4'hF, 0));
        tbl.push_back(mk(0, 1, 4'h5, 4'h0, 4'h7, 4'h0, 4'h0, 4'h7, 4'h0, 4'h0, 0));
        tbl.push_back(mk(0, 1, 4'hF, 4'h3, 4'h0, 4'h0, 4'h0, 4'h7, 4'h0, 4'h3, 0));
        tbl.push_back(mk(0, 1, 4'h6, 4'h1, 4'h5, 4'h9, 4'h0, 4'hA, 4'h0, 4'h4, 0));
        tbl.push_back(mk(0, 1, 4'hB, 4'h6, 4'h0, 4'h0, 4'h0, 4'hA, 4'h6, 4'h5, 0));
        tbl.push_back(mk(0, 1, 4'hB, 4'hF, 4'h3, 4'h0, 4'h0, 4'hA, 4'h2, 4'h6, 1));
        tbl.push_back(mk(0, 0, 4'h0, 4'hF, 4'hF, 4'h0, 4'h0, 4'hA, 4'h2, 4'h6, 1));
        tbl.push_back(mk(0, 0, 4'hE, 4'h3, 4'h1, 4'h0, 4'h0, 4'hA, 4'h2, 4'h6, 1));
        tbl.push_back(mk(0, 0, 4'h6, 4'h9, 4'h9, 4'hF, 4'h0, 4'hA, 4'h2, 4'h6, 1));
        tbl.push_back(mk(0, 1, 4'hF, 4'h9, 4'h8, 4'h0, 4'h0, 4'hA, 4'h2, 4'h1, 1));
        tbl.push_back(mk(0, 1, 4'hE, 4'h0, 4'h0, 4'h0, 4'h0, 4'hA, 4'h2, 4'h2, 0));
        tbl.push_back(mk(0, 1, 4'hC, 4'h4, 4'h0, 4'h0, 4'h0, 4'hA, 4'h2, 4'h4, 0));
        tbl.push_back(mk(0, 1, 4'h2, 4'h4, 4'hF, 4'h3, 4'h7, 4'hA, 4'h2, 4'h5, 0));
        tbl.push_back(mk(1, 0, 4'h3, 4'h5, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 0));
        tbl.push_back(mk(0, 1, 4'h3, 4'h5, 4'h0, 4'h0, 4'h5, 4'h0, 4'h0, 4'h1, 0));
        tbl.push_back(mk(1, 1, 4'h3, 4'h5, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 0));

        foreach (tbl[k]) begin
            apply(tbl[k].rst, tbl[k].en, tbl[k].op, tbl[k].imm, tbl[k].sel, tbl[k].inp);
            check($sformatf("vec%0d", k), tbl[k].r1, tbl[k].r2, tbl[k].out, tbl[k].pc, tbl[k].c);
        end

        // Last table vector was a reset, so the model starts from the reset state.
        m_r1 = 0; m_r2 = 0; m_out = 0; m_pc = 0; m_c = 0;
        for (int n = 0; n < 400; n++) begin
            logic       rr, ee;
            logic [3:0] oo, ii, ss, pp;
            rr = ($urandom_range(0, 31) == 0);
            ee = ($urandom_range(0, 3) != 0);
            oo = 4'($urandom_range(0, 15));
            ii = 4'($urandom_range(0, 15));
            ss = 4'($urandom_range(0, 15));
            pp = 4'($urandom_range(0, 15));
            model_step(rr, ee, int'(oo), int'(ii), int'(ss), int'(pp));
            apply(rr, ee, oo, ii, ss, pp);
            check($sformatf("rand%0d", n), 4'(m_r1), 4'(m_r2), 4'(m_out), 4'(m_pc), m_c[0]);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
